// File: rtl/liteeth_sram_fifo_ctrl.sv
// Streaming FIFO controller driving a 1RW1R SRAM macro, drained into a 2-entry output skid buffer.
// Optional registered almost_full/almost_empty flags: define LITEETH_SRAM_FIFO_ALMOST_EN.
module liteeth_sram_fifo_ctrl #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 384,
  parameter int ADDR_WIDTH = 9
`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
  ,
  parameter int AF_THRESH  = 376,
  parameter int AE_THRESH  = 8
`endif
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BITS-1:0]       s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS-1:0]       m_data,
  output logic [ADDR_WIDTH-1:0] level,
  output logic                  ce_rw1,
  output logic                  we_in_rw1,
  output logic [BITS-1:0]       w_mask_rw1,
  output logic [ADDR_WIDTH-1:0] addr_rw1,
  output logic [BITS-1:0]       wd_in_rw1,
  input  logic [BITS-1:0]       rd_out_rw1,
  output logic                  ce_r1,
  output logic [ADDR_WIDTH-1:0] addr_r1,
  input  logic [BITS-1:0]       rd_out_r1
`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_CNT  = ADDR_WIDTH'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_WIDTH-1:0] mem_cnt, mem_cnt_nxt;
  logic [ADDR_WIDTH-1:0] level_q, level_nxt;
  logic                  inflight, inflight_nxt;
  logic [1:0]            obuf_cnt, obuf_cnt_nxt;
  logic [BITS-1:0]       obuf0, obuf0_nxt;
  logic [BITS-1:0]       obuf1, obuf1_nxt;

  logic       do_write;
  logic       do_issue;
  logic       pop;
  logic [1:0] occ;
  logic       unused_rd_rw;

  // The RW port is only ever written; its read data has no consumer.
  assign unused_rd_rw = ^rd_out_rw1;

  assign m_valid = (obuf_cnt != 2'd0);
  assign m_data  = obuf0;
  assign level   = level_q;
  assign pop     = m_valid & m_ready;

  assign s_ready  = rst_n & ~flush & (mem_cnt != FULL_CNT);
  assign do_write = s_valid & s_ready;

  // A read may be issued when the skid buffer plus the pending read leaves room, counting this cycle's pop.
  assign occ      = obuf_cnt + {1'b0, inflight};
  assign do_issue = rst_n & ~flush & (mem_cnt != '0) &
                    ((occ < 2'd2) | ((occ == 2'd2) & pop));

  assign ce_rw1     = do_write;
  assign we_in_rw1  = do_write;
  assign w_mask_rw1 = '1;
  assign addr_rw1   = do_write ? wr_ptr : '0;
  assign wd_in_rw1  = do_write ? s_data : '0;
  assign ce_r1      = do_issue;
  assign addr_r1    = do_issue ? rd_ptr : '0;

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    obuf0_nxt    = obuf0;
    obuf1_nxt    = obuf1;
    obuf_cnt_nxt = obuf_cnt;
    inflight_nxt = do_issue;
    mem_cnt_nxt  = mem_cnt + ADDR_WIDTH'(do_write) - ADDR_WIDTH'(do_issue);

    if (do_write) wr_ptr_nxt = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ONE;
    if (do_issue) rd_ptr_nxt = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ONE;

    // obuf_cnt never exceeds 1 while a capture is pending, so a push always has a free slot.
    case ({inflight, pop})
      2'b10: begin
        if (obuf_cnt == 2'd0) obuf0_nxt = rd_out_r1;
        else                  obuf1_nxt = rd_out_r1;
        obuf_cnt_nxt = obuf_cnt + 2'd1;
      end
      2'b01: begin
        obuf0_nxt    = obuf1;
        obuf_cnt_nxt = obuf_cnt - 2'd1;
      end
      2'b11: begin
        if (obuf_cnt == 2'd1) begin
          obuf0_nxt = rd_out_r1;
        end else begin
          obuf0_nxt = obuf1;
          obuf1_nxt = rd_out_r1;
        end
      end
      default: ;
    endcase

    if (flush) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      mem_cnt_nxt  = '0;
      inflight_nxt = 1'b0;
      obuf_cnt_nxt = 2'd0;
      obuf0_nxt    = '0;
      obuf1_nxt    = '0;
    end

    level_nxt = mem_cnt_nxt + ADDR_WIDTH'(inflight_nxt) + ADDR_WIDTH'(obuf_cnt_nxt);
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      obuf_cnt <= 2'd0;
      obuf0    <= '0;
      obuf1    <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      mem_cnt  <= mem_cnt_nxt;
      inflight <= inflight_nxt;
      obuf_cnt <= obuf_cnt_nxt;
      obuf0    <= obuf0_nxt;
      obuf1    <= obuf1_nxt;
      level_q  <= level_nxt;
    end
  end

`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_nxt >= ADDR_WIDTH'(AF_THRESH));
      almost_empty <= (level_nxt <= ADDR_WIDTH'(AE_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Directed bench for liteeth_sram_fifo_ctrl with a behavioural SRAM macro and a word scoreboard.
// Define LITEETH_SRAM_FIFO_ALMOST_EN to also check the almost flags every cycle.
module tb_liteeth_sram_fifo_ctrl;

  localparam int BITS       = 32;
  localparam int WORD_DEPTH = 384;
  localparam int ADDR_WIDTH = 9;
  localparam int AF_THRESH  = 376;
  localparam int AE_THRESH  = 8;

  logic                  clk0 = 1'b0;
  logic                  rst_n, flush, s_valid, s_ready, m_valid, m_ready;
  logic [BITS-1:0]       s_data, m_data, w_mask_rw1, wd_in_rw1, rd_out_rw1, rd_out_r1;
  logic [ADDR_WIDTH-1:0] level, addr_rw1, addr_r1;
  logic                  ce_rw1, we_in_rw1, ce_r1;
`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
  logic                  almost_full, almost_empty;
`endif

  always #5 clk0 = ~clk0;

  liteeth_sram_fifo_ctrl #(
    .BITS(BITS), .WORD_DEPTH(WORD_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
    , .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
`endif
  ) dut (
    .clk0(clk0), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ce_rw1(ce_rw1), .we_in_rw1(we_in_rw1), .w_mask_rw1(w_mask_rw1),
    .addr_rw1(addr_rw1), .wd_in_rw1(wd_in_rw1), .rd_out_rw1(rd_out_rw1),
    .ce_r1(ce_r1), .addr_r1(addr_r1), .rd_out_r1(rd_out_r1)
`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  // Behavioural 1RW1R macro: synchronous write, read data one cycle after ce_r1.
  logic [BITS-1:0] mem [WORD_DEPTH];
  assign rd_out_rw1 = '0;
  always @(posedge clk0) begin
    if (ce_rw1 && we_in_rw1)
      mem[addr_rw1] <= (mem[addr_rw1] & ~w_mask_rw1) | (wd_in_rw1 & w_mask_rw1);
    if (ce_r1) rd_out_r1 <= mem[addr_r1];
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  int cyc = 0, n_acc = 0, n_pop = 0;
  int first_acc = -1, first_valid = -1, first_pop = -1, last_pop = -1;
  int max_level = 0, wr_wraps = 0, rd_wraps = 0;
  logic [ADDR_WIDTH-1:0] exp_waddr = '0, exp_raddr = '0;
  logic seen_s_ready = 1'b0, seen_ce_r1 = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic sv, input logic [31:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(negedge clk0);
    cyc++;
    seen_s_ready = s_ready;
    seen_ce_r1   = ce_r1;
    check_val("ce_rw1", 32'(ce_rw1), 32'(s_valid & s_ready));
    check_val("w_mask", w_mask_rw1, 32'hFFFF_FFFF);
`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
    check_val("almost_full", 32'(almost_full), 32'(int'(level) >= AF_THRESH));
    check_val("almost_empty", 32'(almost_empty), 32'(int'(level) <= AE_THRESH));
`endif
    if (!rst_n || flush) begin
      check_val("blocked_s_ready", 32'(s_ready), 32'd0);
      check_val("blocked_ce_r1", 32'(ce_r1), 32'd0);
    end
    if (!rst_n) begin
      check_val("rst_addr_rw1", 32'(addr_rw1), 32'd0);
      check_val("rst_addr_r1", 32'(addr_r1), 32'd0);
      check_val("rst_wd_in", wd_in_rw1, 32'd0);
    end else begin
      check_val("level", 32'(level), 32'(sb.size()));
      if (int'(level) > max_level) max_level = int'(level);
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        check_val("pop_has_data", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check_val("m_data", m_data, sb.pop_front());
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (ce_rw1) begin
        check_val("we_in_rw1", 32'(we_in_rw1), 32'd1);
        check_val("addr_rw1", 32'(addr_rw1), 32'(exp_waddr));
        check_val("wd_in_rw1", wd_in_rw1, s_data);
        if (exp_waddr == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
          exp_waddr = '0;
          wr_wraps++;
        end else exp_waddr = exp_waddr + 1'b1;
      end
      if (ce_r1) begin
        check_val("addr_r1", 32'(addr_r1), 32'(exp_raddr));
        if (exp_raddr == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
          exp_raddr = '0;
          rd_wraps++;
        end else exp_raddr = exp_raddr + 1'b1;
      end
      if (s_valid && s_ready) begin
        sb.push_back(s_data);
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
    end
    if (!rst_n || flush) begin
      sb.delete();
      exp_waddr = '0;
      exp_raddr = '0;
    end
    @(posedge clk0);
    #1;
  endtask

  task automatic drain(input int budget, output int ncyc);
    ncyc = 0;
    while (sb.size() != 0 && ncyc < budget) begin
      cycle(1'b0, 32'd0, 1'b1);
      ncyc++;
    end
    check_val("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // Reset, with an offered word that must not be accepted
    cycle(1'b1, 32'h1111_1111, 1'b1);
    cycle(1'b1, 32'h2222_2222, 1'b1);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_data", m_data, 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
`ifdef LITEETH_SRAM_FIFO_ALMOST_EN
    check_val("rst_almost_empty", 32'(almost_empty), 32'd1);
    check_val("rst_almost_full", 32'(almost_full), 32'd0);
`endif
    rst_n = 1'b1;

    // Four words, empty-FIFO latency and back-to-back output
    first_acc = -1; first_valid = -1; first_pop = -1; last_pop = -1; n_pop = 0;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b1);
    drain(10, n);
    check_val("t1_latency", 32'(first_valid - first_acc), 32'd3);
    check_val("t1_pop_span", 32'(last_pop - first_pop), 32'd3);
    check_val("t1_pops", 32'(n_pop), 32'd4);
    check_val("t1_level", 32'(level), 32'd0);

    // Back-pressure to full
    n_acc = 0;
    for (int k = 0; k < 600; k++) begin
      cycle(1'b1, 32'hA5A5_0000 + 32'(n_acc), 1'b0);
      if (!seen_s_ready) break;
    end
    check_val("bp_accepts", 32'(n_acc), 32'd386);
    check_val("bp_level", 32'(level), 32'd386);
    check_val("bp_s_ready", 32'(s_ready), 32'd0);
    check_val("bp_m_valid", 32'(m_valid), 32'd1);
    check_val("bp_head", m_data, 32'hA5A5_0000);
    drain(1000, n);
    check_val("bp_drain_cycles", 32'(n), 32'd386);
    check_val("bp_level_end", 32'(level), 32'd0);

    // Continuous streaming across the address wrap
    max_level = 0; wr_wraps = 0; rd_wraps = 0; n_acc = 0; n_pop = 0;
    for (int i = 0; i < 1000; i++) cycle(1'b1, 32'(i * 3 + 7), 1'b1);
    check_val("wr_accepts", 32'(n_acc), 32'd1000);
    check_val("wr_pops_steady", 32'(n_pop), 32'd997);
    drain(10, n);
    check_val("wr_max_level_le3", 32'(max_level <= 3), 32'd1);
    check_val("wr_waddr_wrapped", 32'(wr_wraps >= 1), 32'd1);
    check_val("wr_raddr_wrapped", 32'(rd_wraps >= 1), 32'd1);

    // Random handshakes
    for (int i = 0; i < 5000; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    drain(2000, n);

    // Flush with level 100, a read in flight and m_ready low
    for (int i = 0; i < 101; i++) cycle(1'b1, 32'hF000_0000 + 32'(i), 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    check_val("fl_issue_before", 32'(seen_ce_r1), 32'd1);
    check_val("fl_level_before", 32'(level), 32'd100);
    flush = 1'b1;
    cycle(1'b1, 32'h1234_5678, 1'b0);
    flush = 1'b0;
    check_val("fl_level_after", 32'(level), 32'd0);
    check_val("fl_m_valid_after", 32'(m_valid), 32'd0);
    n_pop = 0;
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
    drain(10, n);
    check_val("fl_one_pop", 32'(n_pop), 32'd1);

    // Reset in the middle of a stream
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h5A00_0000 + 32'(i), 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 32'h5A00_00FF, 1'b0);
    rst_n = 1'b1;
    check_val("mr_level", 32'(level), 32'd0);
    check_val("mr_m_valid", 32'(m_valid), 32'd0);
    check_val("mr_m_data", m_data, 32'd0);
    cycle(1'b1, 32'h0BAD_F00D, 1'b1);
    cycle(1'b1, 32'h0000_CAFE, 1'b1);
    drain(10, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
